// File: rtl/seq_multiplier8.sv
// Sequential 8x8 unsigned shift-and-add multiplier driving one Adder8 per iteration.
// Optional feature: define MULT_ZERO_SKIP_EN to finish at once with P=0 when an operand is zero.

module Adder8 (
    input  logic [7:0] i_A,
    input  logic [7:0] i_B,
    input  logic       i_Cin,
    output logic [7:0] o_Sum,
    output logic       o_Cout
);
    logic [8:0] w_carry;

    assign w_carry[0] = i_Cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign o_Sum[i]       = i_A[i] ^ i_B[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_A[i] & i_B[i]) | (w_carry[i] & (i_A[i] ^ i_B[i]));
    end

    assign o_Cout = w_carry[8];
endmodule

module seq_multiplier8 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_A,
    input  logic [7:0]  i_B,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_P
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_m;
    logic [7:0]  r_acc;
    logic [7:0]  r_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_p;
    logic [7:0]  w_sum;
    logic        w_cout;
    logic [8:0]  w_cs;
    logic [7:0]  w_accNext;
    logic [7:0]  w_qNext;
    logic        w_accept;
    logic        w_lastIter;
`ifdef MULT_ZERO_SKIP_EN
    logic        w_zeroOp;
    assign w_zeroOp = (i_A == 8'd0) || (i_B == 8'd0);
`endif

    Adder8 u_adder (
        .i_A    (r_acc),
        .i_B    (r_m),
        .i_Cin  (1'b0),
        .o_Sum  (w_sum),
        .o_Cout (w_cout)
    );

    // The full 9-bit add result is shifted right one place into ACC:Q, so no carry is lost.
    assign w_cs       = r_q[0] ? {w_cout, w_sum} : {1'b0, r_acc};
    assign w_accNext  = w_cs[8:1];
    assign w_qNext    = {w_cs[0], r_q[7:1]};
    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_lastIter = (r_state == S_CALC) && (r_cnt == 4'd7);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef MULT_ZERO_SKIP_EN
                    w_nextState = w_zeroOp ? S_DONE : S_CALC;
`else
                    w_nextState = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (r_cnt == 4'd7) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_CALC);
        o_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m   <= 8'd0;
            r_acc <= 8'd0;
            r_q   <= 8'd0;
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_m   <= i_A;
            r_acc <= 8'd0;
            r_q   <= i_B;
            r_cnt <= 4'd0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_accNext;
            r_q   <= w_qNext;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // P only moves on DONE entry, so it keeps the previous product during a new operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p <= 16'h0000;
        end else if (w_lastIter) begin
            r_p <= {w_accNext, w_qNext};
`ifdef MULT_ZERO_SKIP_EN
        end else if (w_accept && w_zeroOp) begin
            r_p <= 16'h0000;
`endif
        end
    end

    assign o_P = r_p;
endmodule
